sort_seq_ctrl: RTL and testbench
================================

// Module: sort_seq_ctrl
// PURPOSE
//  Sequential sort controller: buffers a block of N words, then sorts it with a single
//  shared compare-exchange unit scheduled as a bubble network. Streams the result out
//  in ascending order. Area-cheap alternative to the fully parallel sort_* networks;
//  sits between a valid/ready producer and a valid/ready consumer.
// PARAMETERS
//  N  8   words per block (N >= 2)
//  W  32  word width; unsigned compare
// PORTS
//  clk          in   1              system clock, all logic on posedge
//  rst          in   1              synchronous, active-high reset
//  in_valid     in   1              producer has in_data
//  in_ready     out  1              controller accepts a word this cycle
//  in_data      in   W              input word
//  out_valid    out  1              out_data valid
//  out_ready    in   1              consumer accepts out_data
//  out_data     out  W              sorted word, smallest first
//  out_last     out  1              marks word N-1 of the block
//  busy         out  1              high in SORT and DRAIN
//  sort_cycles  out  16             SORT-state cycles used by the most recent block
// BEHAVIOUR
//  - Reset: state=LOAD, wr/rd/pass/idx counters=0, out_valid=0, out_last=0, busy=0,
//    sort_cycles=0. in_ready=0 while rst high. The buffer is not cleared.
//  - Reset mid-operation (any state) aborts the block; the partial block is discarded.
//  - LOAD: in_ready=1. Each in_valid&in_ready writes mem[wr], wr++. On beat N-1, the
//    next cycle is SORT. in_ready=0 in all other states.
//  - SORT: one compare-exchange per cycle on (mem[idx], mem[idx+1]); swap only if
//    mem[idx] > mem[idx+1] (stable, equal values never swap). Pass p (0..N-2) covers
//    idx=0..N-2-p. After the final pass -> DRAIN. Fixed SORT time = N(N-1)/2 cycles
//    (28 for N=8). sort_cycles is cleared on SORT entry, +1 per SORT cycle, and holds
//    its value after SORT is left.
//  - DRAIN: out_valid=1, out_data=mem[rd], out_last=(rd==N-1). Advance rd only on
//    out_valid&out_ready. out_data is stable while out_ready is low. After the
//    handshake with out_last=1, the next cycle is LOAD with rd=0 and wr=0. No overlap
//    of LOAD and DRAIN.
//  - Width rules: wr/rd/idx counters are $clog2(N) bits; pass is $clog2(N) bits;
//    sort_cycles saturates at 16'hFFFF.
// CONFIGURATION
//  SORT_EARLY_EXIT_EN defined: a per-pass swapped flag is kept. A pass that ends with
//    no swap goes straight to DRAIN. sort_cycles reports the cycles actually used
//    (already-sorted input: N-1 cycles).
//  Not defined: the swapped flag is absent and SORT always takes N(N-1)/2 cycles.
// STRUCTURE
//  - sort_pkg: data_t (logic [W-1:0] at W=32), state_t enum {LOAD, SORT, DRAIN}, and a
//    localparam for the sort_cycles width (16).
//  - Sub-module sort_cmp_swap: combinational 2-in/2-out, lo=min and hi=max, plus a
//    swap flag; one instance.
//  - This module holds the FSM, counters and the mem[N] register array.
// TESTING
//  1 Reset: hold rst 2 cycles in DRAIN -> state LOAD, out_valid=0, in_ready=1 the
//    cycle after rst falls.
//  2 N=8 input 7,3,9,1,8,2,6,5 -> output 1,2,3,5,6,7,8,9; out_last on 9;
//    sort_cycles=28.
//  3 Duplicates: 4,4,0,FFFFFFFF,4,0,1,1 -> 0,0,1,1,4,4,4,FFFFFFFF (unsigned compare
//    check).
//  4 Backpressure: out_ready low 5 cycles mid-drain -> out_data/out_last held; no word
//    lost or repeated; in_ready stays 0.
//  5 With SORT_EARLY_EXIT_EN, input 0..7 already sorted -> sort_cycles=7; output
//    0..7. Without the macro -> 28.
//  6 Back-to-back blocks with in_valid always high -> the second block is accepted
//    only after the first out_last handshake; both blocks come out sorted.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and constants for the sequential sort controller.
// Optional feature macro used by the controller: SORT_EARLY_EXIT_EN.
package sort_pkg;

    localparam int DATA_W = 32;
    localparam int SC_W   = 16;   // width of the sort_cycles counter

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
        return (&v) ? v : v + SC_W'(1);
    endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Combinational compare-exchange element: lo = min(a,b), hi = max(a,b).
// swap is set only when a > b (unsigned), so equal words never trade places.
module sort_cmp_swap #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi,
    output logic         swap
);

    assign swap = (a > b);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/sort_seq_ctrl.sv
// Sequential sort controller: loads N words, bubble-sorts them with one shared
// compare-exchange unit (one exchange per cycle), then streams them out
// smallest first with valid/ready handshaking.
// Optional feature: define SORT_EARLY_EXIT_EN to leave SORT after the first
// pass that performs no swap.
module sort_seq_ctrl
    import sort_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic            out_last,
    output logic            busy,
    output logic [SC_W-1:0] sort_cycles
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
    localparam logic [CW-1:0] LAST_PASS = CW'(N - 2);

    state_t          state_reg, state_next;
    logic [CW-1:0]   wr_reg, rd_reg, idx_reg, pass_reg;
    logic [CW-1:0]   idx_p1;
    logic [SC_W-1:0] sort_cycles_reg;
    logic [W-1:0]    mem [N];

    logic [W-1:0]    cmp_lo, cmp_hi;
    logic            cmp_swap;
    logic            in_fire, out_fire, pass_end, sort_done;
    logic [N-1:0]    we_vec;
    logic [W-1:0]    wd [N];

`ifdef SORT_EARLY_EXIT_EN
    logic            swapped_reg;
`endif

    assign idx_p1 = idx_reg + CW'(1);

    sort_cmp_swap #(.W(W)) u_cmp (
        .a    (mem[idx_reg]),
        .b    (mem[idx_p1]),
        .lo   (cmp_lo),
        .hi   (cmp_hi),
        .swap (cmp_swap)
    );

    assign in_ready    = (state_reg == LOAD) && !rst;
    assign out_valid   = (state_reg == DRAIN);
    assign out_data    = mem[rd_reg];
    assign out_last    = out_valid && (rd_reg == LAST_IDX);
    assign busy        = (state_reg == SORT) || (state_reg == DRAIN);
    assign sort_cycles = sort_cycles_reg;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    // Pass p ends at idx = N-2-p.
    assign pass_end = (state_reg == SORT) && (idx_reg == (LAST_PASS - pass_reg));

`ifdef SORT_EARLY_EXIT_EN
    assign sort_done = pass_end && ((pass_reg == LAST_PASS) || !(swapped_reg || cmp_swap));
`else
    assign sort_done = pass_end && (pass_reg == LAST_PASS);
`endif

    // Next-state selection for the LOAD -> SORT -> DRAIN cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOAD:    if (in_fire && (wr_reg == LAST_IDX)) state_next = SORT;
            SORT:    if (sort_done)                        state_next = DRAIN;
            DRAIN:   if (out_fire && out_last)             state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // State register and the write/read/pass/index counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= LOAD;
            wr_reg          <= '0;
            rd_reg          <= '0;
            idx_reg         <= '0;
            pass_reg        <= '0;
            sort_cycles_reg <= '0;
`ifdef SORT_EARLY_EXIT_EN
            swapped_reg     <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                LOAD: begin
                    if (in_fire) begin
                        if (wr_reg == LAST_IDX) begin
                            wr_reg          <= '0;
                            idx_reg         <= '0;
                            pass_reg        <= '0;
                            sort_cycles_reg <= '0;
`ifdef SORT_EARLY_EXIT_EN
                            swapped_reg     <= 1'b0;
`endif
                        end else begin
                            wr_reg <= wr_reg + CW'(1);
                        end
                    end
                end
                SORT: begin
                    sort_cycles_reg <= sat_inc(sort_cycles_reg);
                    if (pass_end) begin
                        idx_reg  <= '0;
                        pass_reg <= pass_reg + CW'(1);
`ifdef SORT_EARLY_EXIT_EN
                        swapped_reg <= 1'b0;
`endif
                    end else begin
                        idx_reg <= idx_p1;
`ifdef SORT_EARLY_EXIT_EN
                        swapped_reg <= swapped_reg | cmp_swap;
`endif
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        rd_reg <= out_last ? '0 : rd_reg + CW'(1);
                        if (out_last) wr_reg <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-entry write enables: a load beat targets mem[wr]; a swap rewrites
    // mem[idx] with the smaller word and mem[idx+1] with the larger one.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_wr
            assign we_vec[gi] = ((state_reg == LOAD) && in_fire && (wr_reg == CW'(gi))) ||
                                ((state_reg == SORT) && cmp_swap &&
                                 ((idx_reg == CW'(gi)) || (idx_p1 == CW'(gi))));
            assign wd[gi]     = (state_reg == LOAD)     ? in_data :
                                (idx_reg == CW'(gi))    ? cmp_lo  : cmp_hi;
        end
    endgenerate

    // Buffer storage; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (we_vec[i]) mem[i] <= wd[i];
            end
        end
    end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Directed testbench for sort_seq_ctrl (N=8, W=32).
module tb_sort_seq_ctrl;

    localparam int N = 8;
    localparam int W = 32;
`ifdef SORT_EARLY_EXIT_EN
    localparam int EXP_CYC_MIX    = 25;  // 7+6+5+4+3: pass 4 makes no swap
    localparam int EXP_CYC_SORTED = 7;
`else
    localparam int EXP_CYC_MIX    = 28;
    localparam int EXP_CYC_SORTED = 28;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          busy;
    logic [15:0]   sort_cycles;

    int tests = 0;
    int fails = 0;

    logic [31:0] blk_in  [8];
    logic [31:0] blk_exp [8];

    sort_seq_ctrl #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .sort_cycles (sort_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_block();
        int t;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_data  = blk_in[i];
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 200) begin
                t++;
                @(negedge clk);
            end
            if (!in_ready) begin
                check("load_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 200) begin
            t++;
            @(negedge clk);
        end
        ok = out_valid;
        if (!ok) check("drain_timeout", 32'd0, 32'd1);
    endtask

    // Drain one block with an optional 5-cycle stall before word stall_at.
    task automatic drain_block(input string tag, input int stall_at);
        bit ok;
        wait_out(ok);
        if (!ok) return;
        step();
        for (int i = 0; i < N; i++) begin
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check({tag, "_stall_data"}, out_data, blk_exp[i]);
                    check({tag, "_stall_last"}, {31'd0, out_last}, {31'd0, (i == N - 1)});
                    check({tag, "_stall_inrdy"}, {31'd0, in_ready}, 32'd0);
                    step();
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            $display("[TB] %s word %0d data=%0h last=%0b", tag, i, out_data, out_last);
            check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_data"}, out_data, blk_exp[i]);
            check({tag, "_last"}, {31'd0, out_last}, {31'd0, (i == N - 1)});
            step();
        end
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_post_inrdy"}, {31'd0, in_ready}, 32'd1);
        step();
    endtask

    // Back-to-back test state
    logic [31:0] src [17];
    logic [31:0] bb_exp [16];
    logic [31:0] got [16];
    int nin, nout, nin_at_last, overlap;
    bit acc_in, seen_last;

    initial begin
        bit ok;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // ---- power-on reset
        step();
        @(negedge clk);
        check("por_inrdy_in_rst", {31'd0, in_ready}, 32'd0);
        step();
        @(negedge clk);
        check("por_out_valid", {31'd0, out_valid}, 32'd0);
        check("por_busy", {31'd0, busy}, 32'd0);
        check("por_sort_cycles", {16'd0, sort_cycles}, 32'd0);
        check("por_out_last", {31'd0, out_last}, 32'd0);
        rst = 1'b0;
        step();
        @(negedge clk);
        check("por_inrdy", {31'd0, in_ready}, 32'd1);
        step();

        // ---- test 1: reset while in DRAIN
        blk_in = '{32'd7, 32'd3, 32'd9, 32'd1, 32'd8, 32'd2, 32'd6, 32'd5};
        load_block();
        wait_out(ok);
        check("t1_busy_drain", {31'd0, busy}, 32'd1);
        check("t1_cycles_before", {16'd0, sort_cycles}, EXP_CYC_MIX);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("t1_inrdy_in_rst", {31'd0, in_ready}, 32'd0);
        step();
        @(negedge clk);
        check("t1_out_valid", {31'd0, out_valid}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_sort_cycles", {16'd0, sort_cycles}, 32'd0);
        rst = 1'b0;
        step();
        @(negedge clk);
        check("t1_inrdy_after", {31'd0, in_ready}, 32'd1);
        check("t1_out_valid_after", {31'd0, out_valid}, 32'd0);
        step();

        // ---- test 2: mixed block
        blk_in  = '{32'd7, 32'd3, 32'd9, 32'd1, 32'd8, 32'd2, 32'd6, 32'd5};
        blk_exp = '{32'd1, 32'd2, 32'd3, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
        load_block();
        drain_block("t2", -1);
        check("t2_sort_cycles", {16'd0, sort_cycles}, EXP_CYC_MIX);

        // ---- tests 3+4: duplicates, unsigned extreme, backpressure at word 3
        blk_in  = '{32'd4, 32'd4, 32'd0, 32'hFFFFFFFF, 32'd4, 32'd0, 32'd1, 32'd1};
        blk_exp = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd4, 32'd4, 32'd4, 32'hFFFFFFFF};
        load_block();
        drain_block("t3", 3);

        // ---- test 4b: stall on the final word
        blk_in  = '{32'd20, 32'd10, 32'd30, 32'd0, 32'd5, 32'd25, 32'd15, 32'd35};
        blk_exp = '{32'd0, 32'd5, 32'd10, 32'd15, 32'd20, 32'd25, 32'd30, 32'd35};
        load_block();
        drain_block("t4", 7);

        // ---- test 5: already sorted input
        blk_in  = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
        blk_exp = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
        load_block();
        drain_block("t5", -1);
        check("t5_sort_cycles", {16'd0, sort_cycles}, EXP_CYC_SORTED);

        // ---- test 6: back-to-back blocks, in_valid held high
        src    = '{32'd10, 32'd200, 32'd30, 32'd40, 32'd5, 32'd5, 32'd99, 32'd1,
                   32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        bb_exp = '{32'd1, 32'd5, 32'd5, 32'd10, 32'd30, 32'd40, 32'd99, 32'd200,
                   32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        nin = 0; nout = 0; nin_at_last = -1; overlap = 0; seen_last = 1'b0;
        in_valid  = 1'b1;
        in_data   = src[0];
        out_ready = 1'b1;
        for (int c = 0; c < 400 && nout < 16; c++) begin
            @(negedge clk);
            acc_in = in_valid && in_ready;
            if (in_ready && out_valid) overlap++;
            if (out_valid && out_ready) begin
                got[nout] = out_data;
                $display("[TB] t6 word %0d data=%0h last=%0b", nout, out_data, out_last);
                if (out_last && !seen_last) begin
                    seen_last   = 1'b1;
                    nin_at_last = nin;
                end
                nout++;
            end
            step();
            if (acc_in) nin++;
            in_data = src[(nin < 16) ? nin : 16];
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("t6_words_out", nout, 32'd16);
        check("t6_nin_at_first_last", nin_at_last, 32'd8);
        check("t6_overlap", overlap, 32'd0);
        for (int i = 0; i < 16; i++) begin
            if (i < nout) check($sformatf("t6_data%0d", i), got[i], bb_exp[i]);
            else          check($sformatf("t6_missing%0d", i), 32'd0, 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
